// File: rtl/sobel_window_sequencer.sv
// Multicycle custom-instruction sequencer for the Sobel line-buffer datapath.
// Optional ack watchdog: define SOBEL_ACK_TIMEOUT_EN.
module sobel_window_sequencer #(
    parameter int ROW_PIXELS = 64,
    localparam int SLOTS  = ROW_PIXELS / 8,
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1,
    localparam int COL_W  = $clog2(ROW_PIXELS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              start,
    input  logic [1:0]        n,
    input  logic [31:0]       dataa,
    input  logic [31:0]       datab,
    output logic              done,
    output logic [31:0]       result,
    output logic              row_wr_en,
    output logic [SLOT_W-1:0] row_wr_slot,
    output logic              row_rotate,
    output logic              dp_req,
    output logic [COL_W-1:0]  dp_col,
    output logic              dp_left_edge,
    output logic              dp_right_edge,
    input  logic              dp_ack,
    input  logic [3:0]        dp_mag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_COMPUTE,
        S_ADVANCE,
        S_CLEAR,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_PUSH   = 2'd0;
    localparam logic [1:0] OP_CLEAR  = 2'd1;
    localparam logic [1:0] OP_STATUS = 2'd2;

    state_t            state;
    logic [SLOT_W-1:0] slot;
    logic [1:0]        rows_filled;
    logic [2:0]        k;
    logic              err_bit;
    logic [7:0]        slot_wide;
    logic [31:0]       status_word;

    // The pixel buses feed the line buffers directly; only the write strobe comes from here.
    logic unused_pixels;
    assign unused_pixels = ^{dataa, datab};

`ifdef SOBEL_ACK_TIMEOUT_EN
    logic [3:0] to_cnt;
    logic       err;
    assign err_bit = err;
`else
    assign err_bit = 1'b0;
`endif

    assign slot_wide   = 8'(slot);
    assign status_word = {err_bit, 15'h0, 6'h0, rows_filled, 5'h0, slot_wide[2:0]};

    function automatic logic [COL_W-1:0] col_of(input logic [SLOT_W-1:0] s, input logic [2:0] kk);
        return COL_W'({s, kk});
    endfunction

    function automatic logic is_right(input logic [COL_W-1:0] c);
        return c == COL_W'(ROW_PIXELS - 1);
    endfunction

    // NOTE: every register here is assigned with <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            slot          <= '0;
            rows_filled   <= '0;
            k             <= '0;
            done          <= 1'b0;
            result        <= '0;
            row_wr_en     <= 1'b0;
            row_wr_slot   <= '0;
            row_rotate    <= 1'b0;
            dp_req        <= 1'b0;
            dp_col        <= '0;
            dp_left_edge  <= 1'b0;
            dp_right_edge <= 1'b0;
`ifdef SOBEL_ACK_TIMEOUT_EN
            to_cnt        <= '0;
            err           <= 1'b0;
`endif
        end else if (clk_en) begin
            // Strobes default low so each one is a single-cycle pulse.
            done       <= 1'b0;
            row_wr_en  <= 1'b0;
            row_rotate <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        result <= '0;
                        case (n)
                            OP_PUSH: begin
                                state       <= S_STORE;
                                row_wr_en   <= 1'b1;
                                row_wr_slot <= slot;
                            end
                            OP_CLEAR: state <= S_CLEAR;
                            OP_STATUS: begin
                                result <= status_word;
                                state  <= S_DONE;
                                done   <= 1'b1;
                            end
                            default: begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                end

                S_STORE: begin
                    if (rows_filled == 2'd2) begin
                        state         <= S_COMPUTE;
                        k             <= '0;
                        dp_req        <= 1'b1;
                        dp_col        <= col_of(slot, 3'd0);
                        dp_left_edge  <= (col_of(slot, 3'd0) == '0);
                        dp_right_edge <= is_right(col_of(slot, 3'd0));
`ifdef SOBEL_ACK_TIMEOUT_EN
                        to_cnt        <= '0;
`endif
                    end else begin
                        state <= S_ADVANCE;
                    end
                end

                S_COMPUTE: begin
                    if (dp_ack) begin
                        result[4*k +: 4] <= dp_mag;
`ifdef SOBEL_ACK_TIMEOUT_EN
                        to_cnt           <= '0;
`endif
                        if (k == 3'd7) begin
                            dp_req        <= 1'b0;
                            dp_left_edge  <= 1'b0;
                            dp_right_edge <= 1'b0;
                            state         <= S_ADVANCE;
                        end else begin
                            k             <= k + 3'd1;
                            dp_col        <= col_of(slot, k + 3'd1);
                            dp_left_edge  <= (col_of(slot, k + 3'd1) == '0);
                            dp_right_edge <= is_right(col_of(slot, k + 3'd1));
                        end
                    end
`ifdef SOBEL_ACK_TIMEOUT_EN
                    else if (to_cnt == 4'd15) begin
                        result        <= 32'hFFFF_FFFF;
                        err           <= 1'b1;
                        to_cnt        <= '0;
                        dp_req        <= 1'b0;
                        dp_left_edge  <= 1'b0;
                        dp_right_edge <= 1'b0;
                        state         <= S_ADVANCE;
                    end else begin
                        to_cnt <= to_cnt + 4'd1;
                    end
`endif
                end

                S_ADVANCE: begin
                    if (slot == SLOT_W'(SLOTS - 1)) begin
                        slot       <= '0;
                        row_rotate <= 1'b1;
                        if (rows_filled != 2'd2)
                            rows_filled <= rows_filled + 2'd1;
                    end else begin
                        slot <= slot + SLOT_W'(1);
                    end
                    state <= S_DONE;
                    done  <= 1'b1;
                end

                S_CLEAR: begin
                    slot        <= '0;
                    rows_filled <= '0;
                    k           <= '0;
                    result      <= '0;
`ifdef SOBEL_ACK_TIMEOUT_EN
                    err         <= 1'b0;
`endif
                    state       <= S_DONE;
                    done        <= 1'b1;
                end

                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
